rev_apb_master: RTL and testbench

REV_APB_MASTER -- requirements
Module: rev_apb_master

---
 rtl/rev_apb_pkg.sv | 11 +
 rtl/rev_apb_master.sv | 119 +++++++++++
 tb/tb_rev_apb_master.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rev_apb_pkg.sv
// Shared APB initiator definitions: transfer-phase state encodings.
package rev_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } apb_state_e;

endpackage

// File: rtl/rev_apb_master.sv
// Single-outstanding APB initiator: request/response handshake on one side,
// APB SETUP/ACCESS sequencing with optional pready timeout on the other.
module rev_apb_master
    import rev_apb_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                prstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_write,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic                pready,
    input  logic                pslverr,
    input  logic [DATA_W-1:0]   prdata
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             req_ready_q;
    logic             accept;
    logic             acc_done;
    logic             acc_timeout;

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        acc_done    = 1'b0;
        acc_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // pready in the final counted cycle still completes normally
                if (pready) begin
                    acc_done = 1'b1;
                    state_d  = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    acc_timeout = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            req_ready_q <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            cnt_q       <= '0;
        end else begin
            req_ready_q <= (state_d == IDLE);
            if (accept) begin
                paddr  <= req_addr;
                pwrite <= req_write;
                pwdata <= req_wdata;
                pstrb  <= req_write ? req_strb : '0;
                cnt_q  <= '0;
            end
            if (state_q == ACCESS && !pready) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (acc_done) begin
                rsp_rdata   <= pwrite ? '0 : prdata;
                rsp_err     <= pslverr;
                rsp_timeout <= 1'b0;
            end else if (acc_timeout) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable   = (state_q == ACCESS);
    assign rsp_valid = (state_q == RESP);

endmodule

// File: tb/tb_rev_apb_master.sv
// Bench for rev_apb_master: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rev_apb_master;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          prstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          req_write = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_strb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic [DW-1:0] prdata = '0;

    always #5 pclk = ~pclk;

    rev_apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .prstn(prstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one request in flight, m_k counts APB cycles (0 = setup).
    bit            m_busy, m_resp, m_rr, m_wr, m_err, m_to;
    int            m_k;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rd;
    logic [SW-1:0] m_strb;

    always @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            m_busy = 0; m_resp = 0; m_rr = 0; m_k = 0;
            m_wr = 0; m_err = 0; m_to = 0; m_rd = '0;
        end else begin
            if (m_busy) begin
                if (m_k == 0) m_k = 1;
                else if (pready) begin
                    m_rd = m_wr ? '0 : prdata; m_err = pslverr; m_to = 0;
                    m_busy = 0; m_resp = 1;
                end else if (TO != 0 && m_k == TO) begin
                    m_rd = '0; m_err = 1; m_to = 1;
                    m_busy = 0; m_resp = 1;
                end else m_k++;
            end else if (m_resp) begin
                if (rsp_ready) m_resp = 0;
            end else if (m_rr && req_valid) begin
                m_addr = req_addr; m_wr = req_write; m_wdata = req_wdata;
                m_strb = req_write ? req_strb : '0;
                m_busy = 1; m_k = 0;
            end
            m_rr = !m_busy && !m_resp;
        end
    end

    initial forever begin
        @(negedge pclk);
        if (prstn) begin
            chk("req_ready", req_ready, m_rr);
            chk("psel", psel, m_busy);
            chk("penable", penable, m_busy && m_k >= 1);
            chk("rsp_valid", rsp_valid, m_resp);
            if (m_busy) begin
                chk("paddr", paddr, m_addr);
                chk("pwrite", pwrite, m_wr);
                chk("pwdata", pwdata, m_wdata);
                chk("pstrb", pstrb, m_strb);
            end
            if (m_resp) begin
                chk("rsp_rdata", rsp_rdata, m_rd);
                chk("rsp_err", rsp_err, m_err);
                chk("rsp_timeout", rsp_timeout, m_to);
            end
        end
    end

    // Slave: waits = number of ACCESS cycles before pready; junk outside ACCESS.
    bit            rnd = 0;
    int            sl_waits = 0;
    logic [DW-1:0] sl_rdata = '0;
    bit            sl_err = 0;

    initial begin
        int acc, waits;
        acc = 0; waits = 0;
        forever begin
            @(negedge pclk);
            if (psel && !penable) begin
                acc = 0;
                if (rnd) begin
                    case ($urandom % 8)
                        4: waits = 15;
                        5: waits = 16;
                        6: waits = 30;
                        default: waits = $urandom % 4;
                    endcase
                end else waits = sl_waits;
            end
            if (psel && penable) begin
                pready  = (acc == waits);
                acc++;
                prdata  = rnd ? $urandom : sl_rdata;
                pslverr = rnd ? ($urandom % 4 == 0) : sl_err;
            end else begin
                pready  = $urandom % 2;
                pslverr = $urandom % 2;
                prdata  = $urandom;
            end
            if (rnd) rsp_ready = $urandom % 2;
        end
    end

    task automatic do_req(input logic [AW-1:0] a, input bit w, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
        int t;
        t = 0;
        @(posedge pclk); #1;
        req_valid = 1; req_addr = a; req_write = w; req_wdata = d; req_strb = s;
        forever begin
            @(negedge pclk);
            if (req_ready) break;
            t++;
            if (t > 50) begin chk("accept_bound", 0, 1); break; end
        end
        @(posedge pclk); #1;
        req_valid = 0;
    endtask

    // Observe one transaction from the cycle after acceptance; k=1 is the setup cycle.
    task automatic watch(input int rr_hold, output int psel_n, output int rv_first,
                         output int rv_n, output int rr_back, output bit stable,
                         output bit rr_low, output logic [SW-1:0] strb0,
                         output logic [DW-1:0] rd, output bit err, output bit to);
        logic [AW+DW+SW:0] snap;
        logic [DW+1:0]     rsnap;
        int k;
        k = 0; psel_n = 0; rv_first = 0; rv_n = 0; rr_back = 0; stable = 1; rr_low = 1;
        strb0 = '0; rd = '0; err = 0; to = 0; snap = '0; rsnap = '0;
        rsp_ready = 0;
        while (k < 100) begin
            @(negedge pclk);
            k++;
            if (psel) begin
                if (psel_n == 0) begin snap = {pwrite, paddr, pwdata, pstrb}; strb0 = pstrb; end
                else if ({pwrite, paddr, pwdata, pstrb} !== snap) stable = 0;
                psel_n++;
            end
            if (rsp_valid) begin
                rv_n++;
                if (rv_first == 0) begin
                    rv_first = k; rd = rsp_rdata; err = rsp_err; to = rsp_timeout;
                    rsnap = {rsp_rdata, rsp_err, rsp_timeout};
                end else if ({rsp_rdata, rsp_err, rsp_timeout} !== rsnap) stable = 0;
                if (req_ready) rr_low = 0;
            end
            rsp_ready = rsp_valid && (rv_n > rr_hold);
            if (req_ready && rv_n > 0) begin rr_back = k; break; end
        end
        if (rr_back == 0) chk("watch_bound", 0, 1);
        rsp_ready = 0;
    endtask

    initial begin
        int pn, rf, rn, rb;
        bit st, rl, e, t;
        logic [SW-1:0] s0;
        logic [DW-1:0] rd;

        repeat (2) @(negedge pclk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_psel", psel, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        @(posedge pclk); #2 prstn = 1;
        @(negedge pclk);
        chk("rst_release_ready", req_ready, 0);
        @(negedge pclk);
        chk("first_clock_ready", req_ready, 1);

        // Zero-wait write: minimum latency
        sl_waits = 0; sl_err = 0;
        do_req(4'h2, 1, 32'hA5A5_0F0F, 4'hF);
        watch(0, pn, rf, rn, rb, st, rl, s0, rd, e, t);
        chk("w_psel_cycles", pn, 2);
        chk("w_rsp_at", rf, 3);
        chk("w_ready_back", rb, 4);
        chk("w_pstrb", s0, 4'hF);
        chk("w_err", e, 0);
        chk("w_rdata", rd, 0);

        // Read with three wait states
        sl_waits = 3; sl_rdata = 32'h1234_5678;
        do_req(4'h3, 0, 32'hDEAD_BEEF, 4'hF);
        watch(0, pn, rf, rn, rb, st, rl, s0, rd, e, t);
        chk("r_psel_cycles", pn, 5);
        chk("r_rdata", rd, 32'h1234_5678);
        chk("r_stable", st, 1);
        chk("r_rsp_at", rf, 6);

        // Strobe masking: write keeps strb, read forces zero
        sl_waits = 0;
        do_req(4'h7, 1, 32'h0000_00FF, 4'h5);
        watch(0, pn, rf, rn, rb, st, rl, s0, rd, e, t);
        chk("strb_write", s0, 4'h5);
        do_req(4'h7, 0, 32'h0, 4'hF);
        watch(0, pn, rf, rn, rb, st, rl, s0, rd, e, t);
        chk("strb_read", s0, 4'h0);

        // Silent slave: timeout after 16 ACCESS cycles
        sl_waits = 1000;
        do_req(4'h9, 0, 32'h0, 4'h0);
        watch(0, pn, rf, rn, rb, st, rl, s0, rd, e, t);
        chk("to_psel_cycles", pn, 17);
        chk("to_err", e, 1);
        chk("to_flag", t, 1);
        chk("to_rdata", rd, 0);

        // pready on the 16th ACCESS cycle wins
        sl_waits = 15; sl_rdata = 32'hCAFE_0001;
        do_req(4'h9, 0, 32'h0, 4'h0);
        watch(0, pn, rf, rn, rb, st, rl, s0, rd, e, t);
        chk("edge_psel_cycles", pn, 17);
        chk("edge_flag", t, 0);
        chk("edge_err", e, 0);
        chk("edge_rdata", rd, 32'hCAFE_0001);

        // Slave error with back-pressured response
        sl_waits = 0; sl_err = 1; sl_rdata = 32'h0BAD_0BAD;
        do_req(4'h4, 0, 32'h0, 4'h0);
        watch(4, pn, rf, rn, rb, st, rl, s0, rd, e, t);
        chk("se_err", e, 1);
        chk("se_flag", t, 0);
        chk("se_rv_cycles", rn, 5);
        chk("se_ready_low", rl, 1);
        chk("se_stable", st, 1);
        sl_err = 0;

        // Reset mid-ACCESS abandons the transfer
        sl_waits = 1000;
        do_req(4'h5, 1, 32'h5555_AAAA, 4'h3);
        repeat (4) @(negedge pclk);
        chk("pre_rst_penable", penable, 1);
        #2 prstn = 0;
        #1;
        chk("rst_mid_psel", psel, 0);
        chk("rst_mid_penable", penable, 0);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        chk("rst_mid_pwdata", pwdata, 0);
        @(posedge pclk); #2 prstn = 1;
        sl_waits = 1; sl_rdata = 32'h7777_1111;
        do_req(4'hE, 0, 32'h0, 4'hF);
        watch(0, pn, rf, rn, rb, st, rl, s0, rd, e, t);
        chk("post_rst_rdata", rd, 32'h7777_1111);
        chk("post_rst_rsp_at", rf, 4);

        // Randomized traffic, checked by the model alone
        rnd = 1;
        repeat (3000) begin
            @(posedge pclk); #1;
            req_valid = ($urandom % 3) != 0;
            req_addr  = AW'($urandom);
            req_write = $urandom % 2;
            req_wdata = $urandom;
            req_strb  = SW'($urandom);
        end
        @(posedge pclk); #1 req_valid = 0;
        repeat (5) @(negedge pclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
